// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with match counter
// Optional: define SEQ_DET_OVF_EN for a wrapping counter with sticky count_ovf flag.
module seq_detector_param #(
    parameter int                   PATTERN_W   = 3,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = 3'b010,
    parameter int                   COUNT_W     = 10,
    parameter int                   OVERLAP     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 x,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
    input  logic                 clr_count,
    output logic                 y,
    output logic [COUNT_W-1:0]   users_count,
`ifdef SEQ_DET_OVF_EN
    output logic                 count_ovf,
`endif
    output logic                 busy
);

    localparam int                 FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [PATTERN_W-1:0] r_pattern;
    logic [PATTERN_W-1:0] r_history;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_y;
    logic [COUNT_W-1:0]   r_count;

    logic [PATTERN_W-1:0] w_hist_next;
    logic [FILL_W-1:0]    w_fill_next;
    logic                 w_sample;
    logic                 w_match;

    // A pattern load on the same edge discards the sample.
    always_comb begin
        w_sample    = en && !pat_load;
        w_hist_next = {r_history[PATTERN_W-2:0], x};
        w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
        w_match     = w_sample && (w_fill_next == FILL_FULL) && (w_hist_next == r_pattern);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern <= PATTERN_RST;
            r_history <= '0;
            r_fill    <= '0;
        end else if (pat_load) begin
            r_pattern <= pat_in;
            r_history <= '0;
            r_fill    <= '0;
        end else if (en) begin
            if (w_match && (OVERLAP == 0)) begin
                r_history <= '0;
                r_fill    <= '0;
            end else begin
                r_history <= w_hist_next;
                r_fill    <= w_fill_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_match;
        end
    end

`ifdef SEQ_DET_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr_count) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_match) begin
            if (r_count == COUNT_MAX) begin
                r_count <= '0;
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign count_ovf = r_ovf;
`else
    // Saturating count: further matches still pulse y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (w_match && (r_count != COUNT_MAX)) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end
`endif

    assign y           = r_y;
    assign users_count = r_count;
    assign busy        = (r_fill != '0) && (r_fill != FILL_FULL);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized self-checking bench for seq_detector_param
// Four instances share stimulus; a bit-list reference model predicts each one.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       x;
    logic       pat_load;
    logic [2:0] pat3;
    logic [4:0] pat5;
    logic       clr_count;

    logic       y_w    [4];
    logic       busy_w [4];
    logic [9:0] cnt_a;
    logic [9:0] cnt_b;
    logic [1:0] cnt_c;
    logic [3:0] cnt_d;
`ifdef SEQ_DET_OVF_EN
    logic       ovf_w  [4];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_detector_param u_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat3),
        .clr_count(clr_count), .y(y_w[0]), .users_count(cnt_a),
`ifdef SEQ_DET_OVF_EN
        .count_ovf(ovf_w[0]),
`endif
        .busy(busy_w[0]));

    seq_detector_param #(.OVERLAP(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat3),
        .clr_count(clr_count), .y(y_w[1]), .users_count(cnt_b),
`ifdef SEQ_DET_OVF_EN
        .count_ovf(ovf_w[1]),
`endif
        .busy(busy_w[1]));

    seq_detector_param #(.COUNT_W(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat3),
        .clr_count(clr_count), .y(y_w[2]), .users_count(cnt_c),
`ifdef SEQ_DET_OVF_EN
        .count_ovf(ovf_w[2]),
`endif
        .busy(busy_w[2]));

    seq_detector_param #(.PATTERN_W(5), .PATTERN_RST(5'b10110), .COUNT_W(4), .OVERLAP(1)) u_d (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat5),
        .clr_count(clr_count), .y(y_w[3]), .users_count(cnt_d),
`ifdef SEQ_DET_OVF_EN
        .count_ovf(ovf_w[3]),
`endif
        .busy(busy_w[3]));

    // Reference model: bits received since the last clear, plus expected outputs.
    int W    [4] = '{3, 3, 3, 5};
    int OVL  [4] = '{0, 1, 0, 1};
    int CMAX [4] = '{1023, 1023, 3, 15};
    int PRST [4] = '{2, 2, 2, 22};
    bit m_bits [4][32];
    int m_len  [4];
    int m_pat  [4];
    int m_cnt  [4];
    bit m_ovf  [4];
    bit m_y    [4];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    function automatic int act_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    function automatic int last_value(input int i);
        int v = 0;
        for (int k = 0; k < W[i]; k++)
            v = v * 2 + int'(m_bits[i][m_len[i] - W[i] + k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_len[i] = 0;
            m_pat[i] = PRST[i];
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_y[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            bit m;
            m = 1'b0;
            if (pat_load) begin
                m_pat[i] = (i == 3) ? int'(pat5) : int'(pat3);
                m_len[i] = 0;
            end else if (en) begin
                if (m_len[i] == 32) begin
                    for (int k = 0; k < 16; k++) m_bits[i][k] = m_bits[i][k + 16];
                    m_len[i] = 16;
                end
                m_bits[i][m_len[i]] = x;
                m_len[i]++;
                if (m_len[i] >= W[i] && last_value(i) == m_pat[i]) begin
                    m = 1'b1;
                    if (OVL[i] == 0) m_len[i] = 0;
                end
            end
            m_y[i] = m;
            if (clr_count) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (m) begin
                if (m_cnt[i] == CMAX[i]) begin
`ifdef SEQ_DET_OVF_EN
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b1;
`endif
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            int f;
            f = (m_len[i] < W[i]) ? m_len[i] : W[i];
            check($sformatf("y%0d", i), int'(y_w[i]), int'(m_y[i]));
            check($sformatf("count%0d", i), act_cnt(i), m_cnt[i]);
            check($sformatf("busy%0d", i), int'(busy_w[i]), int'(f != 0 && f != W[i]));
`ifdef SEQ_DET_OVF_EN
            check($sformatf("ovf%0d", i), int'(ovf_w[i]), int'(m_ovf[i]));
`endif
        end
    endtask

    task automatic step(input bit e, input bit xv, input bit pl = 1'b0, input bit clr = 1'b0);
        en        = e;
        x         = xv;
        pat_load  = pl;
        clr_count = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; x = 1'b0; pat_load = 1'b0; clr_count = 1'b0;
        pat3 = 3'b000; pat5 = 5'b00000;
        do_reset();

        // 0,1,0,1,0 with the reset pattern
        step(1, 0); step(1, 1); step(1, 0); step(1, 1); step(1, 0);
        check("plan_cnt_nonoverlap", int'(cnt_a), 1);
        check("plan_cnt_overlap", int'(cnt_b), 2);

        // loaded pattern 110, then a load mid-stream
        pat3 = 3'b110; pat5 = 5'b11011;
        step(1, 0, 1);
        step(1, 1); step(1, 1); step(1, 0); step(1, 1); step(1, 1); step(1, 0);
        step(1, 1); step(1, 1);
        step(1, 1, 1);
        step(1, 0);

        // en=0 window while x toggles
        do_reset();
        step(1, 0); step(1, 1);
        for (int k = 0; k < 5; k++) step(0, k[0]);
        step(1, 0);

        // reset mid-sequence, then clear coincident with a match
        do_reset();
        step(1, 0); step(1, 1);
        do_reset();
        step(1, 0);
        step(1, 1); step(1, 0, 0, 1);
        check("clr_match_y", int'(y_w[0]), 1);
        check("clr_match_cnt", int'(cnt_a), 0);

        // drive the narrow counter through its limit
        for (int k = 0; k < 5; k++) begin
            step(1, 0); step(1, 1); step(1, 0);
        end
        step(0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            pat3 = 3'($urandom);
            pat5 = 5'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
